imm_packer: RTL and testbench
=============================

Name: imm_packer

Overview:
- Encoder counterpart of the processor's immediate extender.
- Accepts instruction fields plus a full 32-bit immediate value and range-checks the value against the selected immediate format.
- Packs the value into the 20-bit immediate field Instr[19:0] and writes the finished 32-bit instruction word into instruction memory at a self-incrementing address.
- Used by the program loader that fills instruction memory with FIR kernels.

Parameters:
- ADDR_W, 10, instruction-memory word address width.
- DEPTH, 1024, maximum words written per load session (must be ≤ 2^ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin load session; latches base_addr and clears counters.
- base_addr  input  ADDR_W  first word address of the session.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_hi  input  12  Instr[31:20] (cond/op/Rd fields).
- in_mid  input  5  Instr[19:15], used only for format 01.
- in_sel  input  2  immediate format, same encoding as ImmSrc.
- in_value  input  32  immediate value as the core must see it after extension.
- mem_we  output  1  write request valid.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  instruction word.
- mem_ready  input  1  memory accepts write when mem_we && mem_ready.
- err_pulse  output  1  one-cycle pulse: last accepted request rejected.
- err_code  output  2  01 overflow, 10 misaligned, 11 illegal format; held until next error.
- word_count  output  ADDR_W+1  words written this session.
- full  output  1  word_count == DEPTH.

Behaviour:
- Reset:
  - State IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - err_pulse=0, err_code=00, word_count=0, full=0.
- FSM states IDLE, RUN, FULL.
  - IDLE→RUN on start.
  - RUN→FULL when a write handshake makes word_count reach DEPTH.
  - start in any state: go to RUN, base latched, word_count=0, pending output word discarded (mem_we=0 next cycle), err_code kept.
- in_ready = (state==RUN) && !start && (!mem_we || mem_ready).
  - IDLE and FULL never accept.
- Encode/check, evaluated on the accepted request, result registered (latency 1 cycle from accept to mem_we):
  - sel 00: value[31:20] must be 0; field = value[19:0].
  - sel 01: value[31:15] must be 0; field = {in_mid, value[14:0]}.
  - sel 10, checked in this order:
    - value[1:0] != 0 → code 10.
    - value[31:21] not all equal to value[21] → code 01.
    - Otherwise field = value[21:2].
  - sel 11: code 11.
  - mem_wdata = {in_hi, field}.
- Round-trip rule: for every written word, the extender's output for (field, sel) equals in_value exactly.
- Rejected request:
  - Handshake still completes.
  - No write issued; word_count unchanged.
  - err_pulse=1 for exactly the cycle after accept; err_code updated that cycle.
- Output register:
  - mem_we, mem_addr and mem_wdata hold stable while mem_we && !mem_ready.
  - mem_addr = (base + word_count) mod 2^ADDR_W, i.e. wraps at the top of memory.
  - word_count increments on each write handshake only.
- Throughput: one word per cycle when mem_ready is held high.
- Back-to-back: an accept in the same cycle as a write handshake loads the next word with no bubble.
- Simultaneous start and write handshake: start wins; the handshake is not counted.
- Reset mid-write: immediate clear of all outputs; the memory must ignore a write whose mem_we drops.

Test Plan:
- Reset, start base=0x000, sel=00 value=0x000ABCDE in_hi=0xE12, mem_ready=1 → next cycle mem_we=1, addr=0x000, wdata=0xE12ABCDE; word_count→1.
- sel=01 value=0x00007FFF in_mid=0x15 in_hi=0x100 → wdata=0x100AFFFF. Then value=0x00008000 → err_pulse, err_code=01, no write.
- sel=10 value=0xFFFFFFF8 (−8) in_hi=0xEA0 → wdata=0xEA0FFFFE. value=0x00000006 → err_code=10. value=0x00200000 → err_code=01.
- sel=11 any value → err_code=11, word_count unchanged.
- Handshake: mem_ready=0 for 3 cycles with mem_we=1 → outputs stable, in_ready=0. Then mem_ready=1 with continuous in_valid → one word per cycle.
- DEPTH=4, base=2^ADDR_W−2: four writes to addresses 0x3FE, 0x3FF, 0x000, 0x001 (wrap); full=1; in_ready=0. Then start → full=0, word_count=0.
- Randomized: 10k requests, all sel values; every written word, passed through the extender model, equals in_value; error codes match the check order.

Source files
------------

// File: rtl/imm_packer.sv
// imm_packer: range-checks a 32-bit immediate against the selected format,
// packs it into Instr[19:0], and streams finished instruction words to
// instruction memory at a self-incrementing address within a load session.
// Ports:
//   clk, reset                 - clock (rising edge), async active-high reset
//   start, base_addr           - open a session at base_addr, clear word_count
//   in_valid/in_ready          - request handshake
//   in_hi, in_mid, in_sel,
//   in_value                   - Instr[31:20], Instr[19:15] (format 01),
//                                format select, extended immediate value
//   mem_we/mem_ready           - write handshake; mem_addr/mem_wdata payload
//   err_pulse, err_code        - reject pulse and sticky reason code
//   word_count, full           - words written this session, session full
module imm_packer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [11:0]       in_hi,
  input  logic [4:0]        in_mid,
  input  logic [1:0]        in_sel,
  input  logic [31:0]       in_value,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count,
  output logic              full
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_pulse_q, err_pulse_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              full_q, full_d;

  logic [1:0]        enc_code;
  logic [19:0]       enc_field;
  logic              accept;
  logic              wr_hs;

  // Output slot is free when empty or draining this cycle; start blocks accepts.
  assign in_ready = (state_q == RUN) && !start && (!mem_we_q || mem_ready);
  assign accept   = in_valid && in_ready;
  assign wr_hs    = mem_we_q && mem_ready;

  // Range check and field packing; enc_code 00 means the value is encodable.
  always_comb begin
    enc_code  = 2'b00;
    enc_field = '0;
    case (in_sel)
      2'b00: begin
        if (in_value[31:20] != '0) enc_code = 2'b01;
        else                       enc_field = in_value[19:0];
      end
      2'b01: begin
        if (in_value[31:15] != '0) enc_code = 2'b01;
        else                       enc_field = {in_mid, in_value[14:0]};
      end
      2'b10: begin
        // Alignment is reported ahead of range.
        if (in_value[1:0] != 2'b00)                    enc_code = 2'b10;
        else if (in_value[31:21] != {11{in_value[21]}}) enc_code = 2'b01;
        else                                           enc_field = in_value[21:2];
      end
      default: enc_code = 2'b11;
    endcase
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;

    if (start) begin
      // Start overrides everything: pending word dropped, handshake not counted.
      state_d    = RUN;
      base_d     = base_addr;
      count_d    = '0;
      mem_we_d   = 1'b0;
      mem_addr_d = base_addr;
    end else begin
      if (wr_hs) begin
        count_d  = count_q + CNT_W'(1);
        mem_we_d = 1'b0;
        if ((state_q == RUN) && (count_d == CNT_W'(DEPTH))) state_d = FULL;
      end
      if (accept) begin
        if (enc_code == 2'b00) begin
          mem_we_d   = 1'b1;
          wdata_d    = {in_hi, enc_field};
          // count_d already includes a same-cycle handshake, so no bubble.
          mem_addr_d = base_q + count_d[ADDR_W-1:0];
        end else begin
          err_pulse_d = 1'b1;
          err_code_d  = enc_code;
        end
      end
    end

    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'b00;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      full_q      <= full_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = wdata_q;
  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;
  assign word_count = count_q;
  assign full       = full_q;

endmodule

// File: tb/tb_imm_packer.sv
module tb_imm_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_hi;
  logic [4:0]  in_mid;
  logic [1:0]  in_sel;
  logic [31:0] in_value;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [10:0] word_count;
  logic        full;

  // Small-depth instance for the session-full and address-wrap scenario.
  logic        s_start;
  logic [9:0]  s_base;
  logic        s_in_valid;
  logic        s_in_ready;
  logic        s_mem_we;
  logic [9:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic        s_mem_ready;
  logic        s_err_pulse;
  logic [1:0]  s_err_code;
  logic [10:0] s_word_count;
  logic        s_full;

  always #5 clk = ~clk;

  imm_packer #(.ADDR_W(10), .DEPTH(1024)) u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_hi(in_hi), .in_mid(in_mid),
    .in_sel(in_sel), .in_value(in_value), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .err_pulse(err_pulse),
    .err_code(err_code), .word_count(word_count), .full(full)
  );

  imm_packer #(.ADDR_W(10), .DEPTH(4)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .base_addr(s_base),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_hi(in_hi), .in_mid(in_mid),
    .in_sel(in_sel), .in_value(in_value), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_ready(s_mem_ready), .err_pulse(s_err_pulse),
    .err_code(s_err_code), .word_count(s_word_count), .full(s_full)
  );

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [31:0] wdata;
    logic [1:0]  sel;
    logic [31:0] value;
  } exp_t;

  exp_t       q[$];
  logic [9:0] s_addrs[$];
  int         total = 0;
  int         bad = 0;
  int         exp_words = 0;
  int         mon_cnt = 0;
  logic [9:0] mon_base = '0;
  bit         rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: range rules expressed on the numeric value.
  function automatic exp_t model(input logic [11:0] hi, input logic [4:0] mid,
                                 input logic [1:0] sel, input logic [31:0] value);
    exp_t e;
    int   s;
    e.is_err = 1; e.code = 2'd0; e.wdata = '0; e.sel = sel; e.value = value;
    s = value;
    case (sel)
      2'd0: if (value < 32'h0010_0000) begin
              e.is_err = 0; e.wdata = (32'(hi) << 20) | value;
            end else e.code = 2'd1;
      2'd1: if (value < 32'h0000_8000) begin
              e.is_err = 0; e.wdata = (32'(hi) << 20) | (32'(mid) << 15) | value;
            end else e.code = 2'd1;
      2'd2: if (value % 4 != 0) e.code = 2'd2;
            else if (s < -2097152 || s >= 2097152) e.code = 2'd1;
            else begin
              e.is_err = 0; e.wdata = (32'(hi) << 20) | (32'(s / 4) & 32'h000F_FFFF);
            end
      default: e.code = 2'd3;
    endcase
    return e;
  endfunction

  // Processor-side immediate extender, used for the round-trip check.
  function automatic logic [31:0] ext(input logic [19:0] f, input logic [1:0] sel);
    int t;
    case (sel)
      2'd0: return 32'(f);
      2'd1: return 32'(f) % 32'h0000_8000;
      default: begin
        t = int'(f);
        if (t >= 524288) t = t - 1048576;
        return 32'(t * 4);
      end
    endcase
  endfunction

  // Monitor: pops one expectation per write handshake or error pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mem_we && mem_ready) begin
        if (q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = q.pop_front();
          check("write_was_expected", 64'(e.is_err), 0);
          check("wdata", mem_wdata, e.wdata);
          check("addr", mem_addr, 10'(mon_base + 10'(mon_cnt)));
          check("roundtrip", ext(mem_wdata[19:0], e.sel), e.value);
        end
        mon_cnt++;
      end
      if (err_pulse) begin
        if (q.size() == 0) check("unexpected_err", 1, 0);
        else begin
          e = q.pop_front();
          check("err_was_expected", 64'(e.is_err), 1);
          check("err_code", err_code, e.code);
        end
      end
      if (start) begin
        mon_base = base_addr;
        mon_cnt  = 0;
      end
    end
  end

  always @(negedge clk)
    if (!reset && s_mem_we && s_mem_ready) s_addrs.push_back(s_mem_addr);

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) mem_ready = ($urandom_range(3) != 0);
  end

  task automatic send(input logic [11:0] hi, input logic [4:0] mid, input logic [1:0] sel,
                      input logic [31:0] val, output int waited);
    exp_t e;
    in_valid = 1; in_hi = hi; in_mid = mid; in_sel = sel; in_value = val;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 0;
    end else begin
      e = model(hi, mid, sel, val);
      q.push_back(e);
      if (!e.is_err) exp_words++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid = 0; rand_ready = 0; mem_ready = 1;
    for (int k = 0; k < 40 && (q.size() != 0 || mem_we || err_pulse); k++) @(negedge clk);
    check("drain_queue_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic start_session(input logic [9:0] b);
    start = 1; base_addr = b;
    @(posedge clk); #1;
    start = 0;
    exp_words = 0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [1:0]  sel;
    logic [31:0] v;
    logic [31:0] edges [9];
    edges = '{32'h000F_FFFF, 32'h0010_0000, 32'h0000_7FFF, 32'h0000_8000, 32'h001F_FFFC,
              32'hFFE0_0000, 32'h0020_0000, 32'hFFDF_FFFC, 32'hFFFF_FFFC};
    reset = 1; start = 0; base_addr = '0; in_valid = 0; in_hi = '0; in_mid = '0;
    in_sel = '0; in_value = '0; mem_ready = 1;
    s_start = 0; s_base = '0; s_in_valid = 0; s_mem_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_code", err_code, 0);
    check("rst_word_count", word_count, 0);
    check("rst_full", full, 0);
    @(posedge clk); #1;

    start_session(10'h000);
    send(12'hE12, 5'h00, 2'd0, 32'h000A_BCDE, w);
    drain();
    check("count_after_first", word_count, 1);

    send(12'h100, 5'h15, 2'd1, 32'h0000_7FFF, w);
    send(12'h100, 5'h15, 2'd1, 32'h0000_8000, w);
    drain();
    check("sel01_overflow_code", err_code, 2'b01);
    check("count_after_sel01", word_count, 2);

    send(12'hEA0, 5'h00, 2'd2, 32'hFFFF_FFF8, w);
    send(12'hEA0, 5'h00, 2'd2, 32'h0000_0006, w);
    drain();
    check("sel10_misaligned_code", err_code, 2'b10);
    send(12'hEA0, 5'h00, 2'd2, 32'h0020_0000, w);
    drain();
    check("sel10_overflow_code", err_code, 2'b01);

    send(12'h123, 5'h00, 2'd3, $urandom, w);
    drain();
    check("sel11_code", err_code, 2'b11);
    check("sel11_count_unchanged", word_count, 3);

    // Stall: word held while memory is not ready.
    mem_ready = 0;
    send(12'hABC, 5'h00, 2'd0, 32'h0001_2345, w);
    in_valid = 1; in_hi = 12'h001; in_sel = 2'd0; in_value = 32'h1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_mem_we", mem_we, 1);
      check("stall_wdata", mem_wdata, 32'hABC1_2345);
      check("stall_addr", mem_addr, 10'd3);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    mem_ready = 1;
    for (int j = 0; j < 8; j++) begin
      send(12'(j), 5'h00, 2'd0, 32'(j * 32'h111), w);
      check("b2b_no_bubble", w, 0);
    end
    drain();
    check("count_after_b2b", word_count, 12);

    start_session(10'h155);
    check("start_keeps_err_code", err_code, 2'b11);
    check("start_clears_count", word_count, 0);
    check("start_full_low", full, 0);

    // Randomized traffic across all formats, with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 10000; i++) begin
      if (i % 400 == 399) begin
        drain();
        check("session_count", word_count, exp_words);
        start_session(10'($urandom));
        rand_ready = 1;
      end
      if ($urandom_range(7) == 0) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
      sel = 2'($urandom_range(3));
      case ($urandom_range(3))
        0: v = $urandom;
        1, 3: begin
          case (sel)
            2'd0: v = $urandom & 32'h000F_FFFF;
            2'd1: v = $urandom & 32'h0000_7FFF;
            default: begin
              v = $urandom & 32'h003F_FFFC;
              if (v[21]) v = v | 32'hFFC0_0000;
            end
          endcase
        end
        default: v = edges[$urandom_range(8)];
      endcase
      if ($urandom_range(7) == 0) v = v ^ (32'h1 << $urandom_range(31));
      send(12'($urandom), 5'($urandom), sel, v, w);
    end
    drain();
    check("final_count", word_count, exp_words);

    // DEPTH=4 session at the top of memory: wrap and full.
    in_hi = 12'h0AA; in_mid = '0; in_sel = 2'd0;
    s_base = 10'h3FE; s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    for (int k = 0; k < 4; k++) begin
      s_in_valid = 1; in_value = 32'(k);
      @(negedge clk);
      for (int t = 0; t < 10 && !s_in_ready; t++) @(negedge clk);
      check("small_accept", s_in_ready, 1);
      @(posedge clk); #1;
    end
    s_in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("small_write_count", s_addrs.size(), 4);
    if (s_addrs.size() == 4) begin
      check("small_addr0", s_addrs[0], 10'h3FE);
      check("small_addr1", s_addrs[1], 10'h3FF);
      check("small_addr2", s_addrs[2], 10'h000);
      check("small_addr3", s_addrs[3], 10'h001);
    end
    check("small_full", s_full, 1);
    check("small_word_count", s_word_count, 4);
    s_in_valid = 1;
    @(negedge clk);
    check("small_full_no_ready", s_in_ready, 0);
    @(posedge clk); #1;
    s_in_valid = 0; s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    @(negedge clk);
    check("small_restart_full", s_full, 0);
    check("small_restart_count", s_word_count, 0);
    check("small_no_extra_write", s_addrs.size(), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
